// File: rtl/riscv_uart_io_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O sequencer: register offsets,
// default window base and the 2-bit sequencer state encoding.
package riscv_uart_io_ctrl_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_0400;

    localparam logic [7:0] IO_TXDATA = 8'h00;
    localparam logic [7:0] IO_RXDATA = 8'h04;
    localparam logic [7:0] IO_STATUS = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX_BUSY = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_DONE = 2'd3
    } io_state_e;

endpackage

// File: rtl/riscv_uart_io_ctrl_if.sv
// Bundle of datapath/UART signals seen by the I/O sequencer.
// Handshake: uart_start and uart_read_en are single-cycle strobes; stall=1 means the
// core holds addr/mem_write/mem_read stable until a cycle with stall=0 retires them.
interface riscv_uart_io_ctrl_if;
    import riscv_uart_io_ctrl_pkg::*;

    logic [31:0] addr;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] uart_rdata;
    logic        uart_rx_valid;
    logic        dmem_write;
    logic        dmem_read;
    logic        uart_start;
    logic        uart_read_en;
    logic        uart_sel;
    logic [31:0] io_rdata;
    logic        stall;
    logic        tx_busy;
    io_state_e   dbg_state;

    modport master (
        output addr, mem_write, mem_read, uart_rdata, uart_rx_valid,
        input  dmem_write, dmem_read, uart_start, uart_read_en, uart_sel,
               io_rdata, stall, tx_busy, dbg_state
    );

    modport slave (
        input  addr, mem_write, mem_read, uart_rdata, uart_rx_valid,
        output dmem_write, dmem_read, uart_start, uart_read_en, uart_sel,
               io_rdata, stall, tx_busy, dbg_state
    );

endinterface

// File: rtl/riscv_uart_io_ctrl_io_addr_decode.sv
// Combinational decode of a 256-byte peripheral window: hit flag and byte offset.
module io_addr_decode #(
    parameter logic [31:0] BASE = 32'h0000_0400
) (
    input  logic [31:0] addr,
    output logic        hit,
    output logic [7:0]  offset
);

    assign hit    = (addr[31:8] == BASE[31:8]);
    assign offset = addr[7:0];

endmodule

// File: rtl/riscv_uart_io_ctrl.sv
// UART I/O sequencer: decodes window hits, issues UART start/read strobes,
// gates data memory and stalls the core while a UART access is outstanding.
module riscv_uart_io_ctrl
    import riscv_uart_io_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT,
    parameter int          TX_FRAME_CYCLES = 10417,
    parameter int          RD_LATENCY      = 2,
    parameter int          CNT_W           = 14
) (
    input logic               clk,
    input logic               reset,
    riscv_uart_io_ctrl_if.slave bus
);

    logic             hit;
    logic [7:0]       offset;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rd_cnt;
    io_state_e        rd_state;
    io_state_e        rd_next;
    logic             tx_active;
    logic             wr_hit;
    logic             rd_hit;
    logic             tx_wr;
    logic             rx_rd;
    logic             st_rd;
    logic             rd_load;
    logic             start;
    logic             read_en;
    logic             sel;
    logic             stall;
    logic [31:0]      rdata;

    io_addr_decode #(.BASE(IO_BASE)) u_decode (
        .addr   (bus.addr),
        .hit    (hit),
        .offset (offset)
    );

    // The transmitter is occupied while its frame counter is non-zero.
    assign tx_active = (tx_cnt != '0);
    // A simultaneous write and read to the window is treated as a write only.
    assign wr_hit    = hit & bus.mem_write;
    assign rd_hit    = hit & bus.mem_read & ~bus.mem_write;
    assign tx_wr     = wr_hit & (offset == IO_TXDATA);
    assign rx_rd     = rd_hit & (offset == IO_RXDATA);
    assign st_rd     = rd_hit & (offset == IO_STATUS);

    always_comb begin
        rd_next = rd_state;
        rd_load = 1'b0;
        start   = 1'b0;
        read_en = 1'b0;
        sel     = 1'b0;
        stall   = 1'b0;
        rdata   = '0;

        if (tx_wr) begin
            if (tx_active) stall = 1'b1;
            else           start = 1'b1;
        end

        case (rd_state)
            ST_IDLE: begin
                if (rx_rd) begin
                    read_en = 1'b1;
                    stall   = 1'b1;
                    rd_load = 1'b1;
                    rd_next = (RD_LATENCY <= 1) ? ST_RD_DONE : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                stall = 1'b1;
                if (rd_cnt <= CNT_W'(1)) rd_next = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                if (rx_rd) begin
                    sel   = 1'b1;
                    rdata = bus.uart_rdata;
                end
                rd_next = ST_IDLE;
            end
            default: rd_next = ST_IDLE;
        endcase

        if (st_rd) begin
            sel   = 1'b1;
            rdata = {30'b0, bus.uart_rx_valid, tx_active};
        end else if (rd_hit && !rx_rd) begin
            sel = 1'b1;
        end

        // Nothing may reach the UART or the core while reset is held.
        if (reset) begin
            start   = 1'b0;
            read_en = 1'b0;
            sel     = 1'b0;
            stall   = 1'b0;
            rdata   = '0;
            rd_load = 1'b0;
            rd_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state <= ST_IDLE;
            tx_cnt   <= '0;
            rd_cnt   <= '0;
        end else begin
            rd_state <= rd_next;
            if (start)          tx_cnt <= CNT_W'(TX_FRAME_CYCLES - 1);
            else if (tx_active) tx_cnt <= tx_cnt - CNT_W'(1);
            if (rd_load)              rd_cnt <= CNT_W'(RD_LATENCY - 1);
            else if (rd_cnt != '0)    rd_cnt <= rd_cnt - CNT_W'(1);
        end
    end

    assign bus.dmem_write   = bus.mem_write & ~hit;
    assign bus.dmem_read    = bus.mem_read & ~hit;
    assign bus.uart_start   = start;
    assign bus.uart_read_en = read_en;
    assign bus.uart_sel     = sel;
    assign bus.io_rdata     = rdata;
    assign bus.stall        = stall;
    assign bus.tx_busy      = tx_active | start;
    assign bus.dbg_state    = (rd_state != ST_IDLE) ? rd_state
                            : (tx_active ? ST_TX_BUSY : ST_IDLE);

endmodule

// File: tb/tb_riscv_uart_io_ctrl.sv
// Self-checking bench for riscv_uart_io_ctrl: cycle-level timestamp model plus
// directed scenarios with hand-computed expectations.
module tb_riscv_uart_io_ctrl;
    import riscv_uart_io_ctrl_pkg::*;

    localparam int TX_N = 10417;
    localparam int RD_L = 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    riscv_uart_io_ctrl_if bus();

    riscv_uart_io_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    // ---------------- behavioural model + compare ----------------
    // Transmitter free from cycle m_tx_end onwards; a read issued at m_rd_issue
    // delivers data RD_L cycles later.
    int m_tx_end = 0;
    int m_rd_issue = 0;
    bit m_rd_active = 1'b0;

    always @(negedge clk) begin
        logic        hit, w, r, busy;
        logic [7:0]  off;
        logic        e_st, e_re, e_sel, e_stall;
        logic [31:0] e_rd;
        logic [38:0] exp_v, act_v;
        hit = (bus.addr[31:8] == 24'h000004);
        off = bus.addr[7:0];
        w = bus.mem_write;
        r = bus.mem_read & ~bus.mem_write;
        e_st = 0; e_re = 0; e_sel = 0; e_stall = 0; e_rd = 0;
        if (reset) begin
            m_tx_end = 0;
            m_rd_active = 0;
            busy = 0;
        end else begin
            if (hit && w && off == 8'h00) begin
                if (cyc < m_tx_end) e_stall = 1;
                else begin
                    e_st = 1;
                    m_tx_end = cyc + TX_N;
                end
            end
            busy = (cyc < m_tx_end);
            if (m_rd_active) begin
                if (cyc < m_rd_issue + RD_L) e_stall = 1;
                else begin
                    if (hit && r && off == 8'h04) begin
                        e_sel = 1;
                        e_rd = bus.uart_rdata;
                    end
                    m_rd_active = 0;
                end
            end else if (hit && r && off == 8'h04) begin
                e_re = 1;
                e_stall = 1;
                m_rd_active = 1;
                m_rd_issue = cyc;
            end
            if (hit && r && off == 8'h08) begin
                e_sel = 1;
                e_rd = {30'b0, bus.uart_rx_valid, busy};
            end else if (hit && r && off != 8'h04) begin
                e_sel = 1;
            end
        end
        exp_v = {bus.mem_write & ~hit, bus.mem_read & ~hit, e_st, e_re, e_sel, e_stall, busy, e_rd};
        act_v = {bus.dmem_write, bus.dmem_read, bus.uart_start, bus.uart_read_en,
                 bus.uart_sel, bus.stall, bus.tx_busy, bus.io_rdata};
        check($sformatf("cycle_outputs@%0d", cyc), 64'(act_v), 64'(exp_v));
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.addr = 32'h0;
        bus.mem_write = 1'b0;
        bus.mem_read = 1'b0;
    endtask

    // One instruction: held until a cycle with stall=0 retires it.
    task automatic instr(input logic w, input logic r, input logic [31:0] a,
                         output int stalls, output int starts, output int rdens,
                         output logic [35:0] snap);
        bit done = 0;
        bus.addr = a;
        bus.mem_write = w;
        bus.mem_read = r;
        stalls = 0; starts = 0; rdens = 0; snap = '0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            starts += int'(bus.uart_start);
            rdens  += int'(bus.uart_read_en);
            if (!bus.stall) begin
                snap = {bus.dmem_write, bus.dmem_read, bus.uart_sel, bus.tx_busy, bus.io_rdata};
                done = 1;
                break;
            end
            stalls++;
        end
        if (!done) check("instr_timeout", 64'(stalls), 64'(0));
        @(posedge clk); #1;
        set_idle();
    endtask

    // Counts further cycles with tx_busy=1 (bounded), then realigns after posedge.
    task automatic wait_tx_idle(output int busy_cycles);
        bit done = 0;
        busy_cycles = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (!bus.tx_busy) begin done = 1; break; end
            busy_cycles++;
        end
        if (!done) check("tx_idle_timeout", 64'(busy_cycles), 64'(0));
        @(posedge clk); #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int st, sn, rn, bc, total_starts;
        logic [35:0] snap;
        reset = 1'b1;
        set_idle();
        bus.uart_rdata = 32'h0;
        bus.uart_rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall",   64'(bus.stall), 64'(0));
        check("rst_txbusy",  64'(bus.tx_busy), 64'(0));
        check("rst_strobes", 64'({bus.uart_start, bus.uart_read_en, bus.uart_sel}), 64'(0));
        check("rst_iordata", 64'(bus.io_rdata), 64'(0));
        check("rst_state",   64'(bus.dbg_state), 64'(ST_IDLE));
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: single transmit
        instr(1, 0, 32'h400, st, sn, rn, snap);
        check("t1_stall", 64'(st), 64'(0));
        check("t1_start", 64'(sn), 64'(1));
        check("t1_dmem_write", 64'(snap[35]), 64'(0));
        check("t1_state", 64'(bus.dbg_state), 64'(ST_TX_BUSY));
        wait_tx_idle(bc);
        check("t1_busy_cycles", 64'(bc + int'(snap[32])), 64'(10417));

        // 2: back-to-back transmit
        instr(1, 0, 32'h400, st, sn, rn, snap);
        total_starts = sn;
        instr(1, 0, 32'h400, st, sn, rn, snap);
        total_starts += sn;
        check("t2_stall", 64'(st), 64'(10416));
        check("t2_starts", 64'(total_starts), 64'(2));

        // 3: RXDATA read while transmitter still busy
        bus.uart_rdata = 32'h41;
        instr(0, 1, 32'h404, st, sn, rn, snap);
        check("t3_stall", 64'(st), 64'(2));
        check("t3_read_en", 64'(rn), 64'(1));
        check("t3_sel", 64'(snap[33]), 64'(1));
        check("t3_rdata", 64'(snap[31:0]), 64'(32'h41));

        // 4: STATUS while transmitting with rx data pending
        bus.uart_rx_valid = 1'b1;
        instr(0, 1, 32'h408, st, sn, rn, snap);
        check("t4_stall", 64'(st), 64'(0));
        check("t4_status", 64'(snap[31:0]), 64'(32'h3));
        bus.uart_rx_valid = 1'b0;

        // 5: pass-through and unmapped offsets
        instr(1, 0, 32'h000, st, sn, rn, snap);
        check("t5_dmem_write", 64'({snap[35], sn}), 64'({1'b1, 32'd0}));
        instr(0, 1, 32'h0FC, st, sn, rn, snap);
        check("t5_dmem_read", 64'({snap[34], snap[33], rn}), 64'({1'b1, 1'b0, 32'd0}));
        instr(1, 0, 32'h40C, st, sn, rn, snap);
        check("t5_sw_40c", 64'({st, sn}), 64'(0));
        instr(0, 1, 32'h40C, st, sn, rn, snap);
        check("t5_lw_40c", 64'({st, snap[31:0]}), 64'(0));
        instr(1, 1, 32'h404, st, sn, rn, snap);
        check("t5_write_wins", 64'({st, rn}), 64'(0));

        wait_tx_idle(bc);
        instr(0, 1, 32'h408, st, sn, rn, snap);
        check("t5_status_idle", 64'(snap[31:0]), 64'(32'h0));

        // 6: reset in the middle of a frame, with a second write stalled
        instr(1, 0, 32'h400, st, sn, rn, snap);
        repeat (499) @(posedge clk);
        #1;
        bus.addr = 32'h400;
        bus.mem_write = 1'b1;
        #1;
        check("t6_stalled", 64'(bus.stall), 64'(1));
        reset = 1'b1;
        #1;
        check("t6_rst_stall", 64'(bus.stall), 64'(0));
        check("t6_rst_busy", 64'(bus.tx_busy), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle();
        @(posedge clk); #1;
        instr(1, 0, 32'h400, st, sn, rn, snap);
        check("t6_restart", 64'({st, sn}), 64'({32'd0, 32'd1}));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
